// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmitter arbiter: FSM state encodings and the byte width.
package uart_arb_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RETRY = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational winner picker: round-robin from rr_ptr by default, or fixed priority
// (lowest index wins) when UART_ARB_FIXED_PRIO_EN is defined.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

`ifdef UART_ARB_FIXED_PRIO_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;
`endif

  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'(i);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
`else
    // Search begins at rr_ptr and wraps, so the last owner is checked last.
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
`endif
    win = found ? (N_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uarttx byte transmitter between N_REQ requesters; holds the FSM, the tx_data latch,
// the start timeout and rr_ptr. Define UART_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int START_TMO = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic                    busy,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_en,
  input  logic                    tx_status,
  output arb_state_t              state_dbg
);

  // Handshake: a requester raises req with its byte on req_data and keeps req up until its
  // one-cycle ack; the byte is captured when grant rises and may change afterwards.
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMO_W = $clog2(START_TMO) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);

  arb_state_t        state, state_next;
  logic [TMO_W-1:0]  tmo;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  win_idx;
  logic [N_REQ-1:0]  win;
  logic [DATA_W-1:0] slot [N_REQ];
  logic              arb_go;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign slot[g] = req_data[g*DATA_W +: DATA_W];
  end

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // A low tx_status in IDLE means uarttx is still finishing a frame from before a reset.
  assign arb_go    = (state == IDLE) && (|req) && tx_status;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_go) state_next = START;
      START: begin
        if (!tx_status)            state_next = SEND;
        else if (tmo == TMO_LAST)  state_next = RETRY;
      end
      RETRY:   state_next = START;
      SEND:    if (tx_status) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant   <= '0;
      ack     <= '0;
      tx_data <= '0;
      tx_en   <= 1'b0;
      tmo     <= '0;
    end else begin
      tx_en <= (state_next == START);
      ack   <= (state == SEND && tx_status) ? grant : '0;
      if (arb_go) begin
        grant   <= win;
        tx_data <= slot[win_idx];
      end else if (state == DONE) begin
        grant <= '0;
      end
      // Counts START cycles only; any exit (including RETRY) restarts the window.
      if (state == START && state_next == START) begin
        if (tmo != '1) tmo <= tmo + 1'b1;
      end else begin
        tmo <= '0;
      end
    end
  end

`ifdef UART_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IDX_W-1:0] own_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_idx <= '0;
      rr_ptr  <= '0;
    end else begin
      if (arb_go) own_idx <= win_idx;
      if (state == DONE)
        rr_ptr <= (own_idx == IDX_W'(N_REQ - 1)) ? '0 : own_idx + 1'b1;
    end
  end
`endif

endmodule
